// File: rtl/decode_queue_if.sv
// Handshake bundle for decode_queue: fetch-side push port and rename/issue-side pop port.
interface decode_queue_if #(
  parameter int unsigned LANES = 2
);
  logic                  in_valid;
  logic                  in_ready;
  logic [32*LANES-1:0]   in_instr;
  logic [LANES-1:0]      in_lane_valid;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*LANES-1:0]    out_op;
  logic [4*LANES-1:0]    out_des;
  logic [4*LANES-1:0]    out_s1;
  logic [4*LANES-1:0]    out_s2;
  logic [5*LANES-1:0]    out_imm;
  logic [LANES-1:0]      out_lane_valid;
  logic [LANES-1:0]      out_illegal;

  modport slave (
    input  in_valid, in_instr, in_lane_valid, out_ready,
    output in_ready, out_valid, out_op, out_des, out_s1, out_s2,
           out_imm, out_lane_valid, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_lane_valid, out_ready,
    input  in_ready, out_valid, out_op, out_des, out_s1, out_s2,
           out_imm, out_lane_valid, out_illegal
  );
endinterface

// File: rtl/decode_queue.sv
// Multi-lane instruction decoder feeding a DEPTH-entry FIFO of decoded bundles,
// with optional strict-opcode checking, post-branch truncation and an issue counter.
module decode_queue #(
  parameter int unsigned LANES    = 2,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned STRICT   = 0,
  parameter int unsigned TRUNC_BR = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  decode_queue_if.slave    bus,
  output logic [CNT_W-1:0] issued_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned SW = CNT_W + 4;

  typedef struct packed {
    logic [LANES-1:0]   ill;
    logic [LANES-1:0]   lv;
    logic [5*LANES-1:0] imm;
    logic [4*LANES-1:0] s2;
    logic [4*LANES-1:0] s1;
    logic [4*LANES-1:0] des;
    logic [4*LANES-1:0] op;
  } entry_t;

  entry_t            dec;
  entry_t            head;
  entry_t            mem_q [DEPTH];
  logic              br_seen;

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW:0]       cnt_q, cnt_d;
  logic              rdy_q;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [SW-1:0]     pc, sum;
  logic              push, pop, empty;

  always_comb begin
    dec     = '0;
    br_seen = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (bus.in_lane_valid[i]) begin
        dec.lv[i] = 1'b1;
        case (bus.in_instr[32*i+26 +: 6])
          6'b000000: begin
            dec.op[4*i +: 4]  = 4'b1000;
            dec.des[4*i +: 4] = bus.in_instr[32*i+22 +: 4];
            dec.s1[4*i +: 4]  = bus.in_instr[32*i+18 +: 4];
            dec.s2[4*i +: 4]  = bus.in_instr[32*i+14 +: 4];
          end
          6'b100011: begin
            dec.op[4*i +: 4]  = 4'b0100;
            dec.des[4*i +: 4] = bus.in_instr[32*i+22 +: 4];
            dec.s1[4*i +: 4]  = bus.in_instr[32*i+18 +: 4];
            dec.imm[5*i +: 5] = bus.in_instr[32*i+9 +: 5];
          end
          6'b101011: begin
            dec.op[4*i +: 4]  = 4'b0010;
            dec.s1[4*i +: 4]  = bus.in_instr[32*i+18 +: 4];
            dec.s2[4*i +: 4]  = bus.in_instr[32*i+14 +: 4];
            dec.imm[5*i +: 5] = bus.in_instr[32*i+9 +: 5];
          end
          default: begin
            if (STRICT == 0 || bus.in_instr[32*i+26 +: 6] == 6'b000100) begin
              dec.op[4*i +: 4]  = 4'b0001;
              dec.s1[4*i +: 4]  = bus.in_instr[32*i+18 +: 4];
              dec.s2[4*i +: 4]  = bus.in_instr[32*i+14 +: 4];
              dec.imm[5*i +: 5] = bus.in_instr[32*i+9 +: 5];
            end else begin
              dec.ill[i] = 1'b1;
            end
          end
        endcase
      end
      // Truncated lanes are scrubbed entirely, illegal flag included.
      if (TRUNC_BR != 0 && br_seen) begin
        dec.op[4*i +: 4]  = '0;
        dec.des[4*i +: 4] = '0;
        dec.s1[4*i +: 4]  = '0;
        dec.s2[4*i +: 4]  = '0;
        dec.imm[5*i +: 5] = '0;
        dec.lv[i]         = 1'b0;
        dec.ill[i]        = 1'b0;
      end else if (dec.lv[i] && dec.op[4*i +: 4] == 4'b0001) begin
        br_seen = 1'b1;
      end
    end
  end

  assign empty        = (cnt_q == '0);
  assign bus.in_ready = rdy_q && (cnt_q != (PW+1)'(DEPTH));
  assign bus.out_valid = !empty;
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = bus.out_valid && bus.out_ready;
  assign head         = empty ? '0 : mem_q[rd_ptr_q];

  assign bus.out_op         = head.op;
  assign bus.out_des        = head.des;
  assign bus.out_s1         = head.s1;
  assign bus.out_s2         = head.s2;
  assign bus.out_imm        = head.imm;
  assign bus.out_lane_valid = head.lv;
  assign bus.out_illegal    = head.ill;
  assign issued_cnt         = issued_q;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
    pc = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      pc = pc + SW'(head.lv[i]);
    end
    sum      = SW'(issued_q) + pc;
    issued_d = issued_q;
    if (pop) begin
      issued_d = (sum[SW-1:CNT_W] != '0) ? '1 : sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rdy_q    <= 1'b0;
      issued_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      rdy_q    <= 1'b1;
      issued_q <= issued_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= dec;
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: four instances cover default, strict,
// 4-lane truncating and narrow-counter configurations.
module tb_decode_queue;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [15:0] cnt0, cnt1, cnt2;
  logic [2:0]  cnt3;

  always #5 clk = ~clk;

  decode_queue_if #(.LANES(2)) b0 ();
  decode_queue_if #(.LANES(2)) b1 ();
  decode_queue_if #(.LANES(4)) b2 ();
  decode_queue_if #(.LANES(2)) b3 ();

  decode_queue #(.LANES(2), .DEPTH(4), .STRICT(0), .TRUNC_BR(0), .CNT_W(16))
    u0 (.clk(clk), .reset(reset), .bus(b0.slave), .issued_cnt(cnt0));
  decode_queue #(.LANES(2), .DEPTH(4), .STRICT(1), .TRUNC_BR(0), .CNT_W(16))
    u1 (.clk(clk), .reset(reset), .bus(b1.slave), .issued_cnt(cnt1));
  decode_queue #(.LANES(4), .DEPTH(4), .STRICT(0), .TRUNC_BR(1), .CNT_W(16))
    u2 (.clk(clk), .reset(reset), .bus(b2.slave), .issued_cnt(cnt2));
  decode_queue #(.LANES(2), .DEPTH(4), .STRICT(0), .TRUNC_BR(0), .CNT_W(3))
    u3 (.clk(clk), .reset(reset), .bus(b3.slave), .issued_cnt(cnt3));

  task automatic test_reset();
    #12;
    total++;
    if ({b0.in_ready, b0.out_valid, cnt0, b0.out_op, b0.out_lane_valid} !== '0) begin
      bad++;
      $display("FAIL reset_state got rdy=%b vld=%b cnt=%0d op=%h lv=%b required all 0",
               b0.in_ready, b0.out_valid, cnt0, b0.out_op, b0.out_lane_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (b0.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL ready_before_edge got=%b required=0", b0.in_ready);
    end
    @(negedge clk);
    total++;
    if ({b0.in_ready, b0.out_valid} !== 2'b10) begin
      bad++;
      $display("FAIL ready_after_edge got rdy=%b vld=%b required rdy=1 vld=0",
               b0.in_ready, b0.out_valid);
    end
  endtask

  task automatic test_basic();
    b0.in_valid = 1'b1;
    b0.in_instr = {32'h8C440A00, 32'h00448000};
    b0.in_lane_valid = 2'b11;
    b0.out_ready = 1'b1;
    @(negedge clk);
    b0.in_valid = 1'b0;
    total++;
    if ({b0.out_valid, b0.out_op, b0.out_des, b0.out_s1, b0.out_s2, b0.out_imm,
         b0.out_lane_valid, b0.out_illegal}
        !== {1'b1, 8'h48, 8'h11, 8'h11, 8'h02, 10'h0A0, 2'b11, 2'b00}) begin
      bad++;
      $display("FAIL basic_decode got vld=%b op=%h des=%h s1=%h s2=%h imm=%h lv=%b ill=%b required 1 48 11 11 02 0a0 11 00",
               b0.out_valid, b0.out_op, b0.out_des, b0.out_s1, b0.out_s2, b0.out_imm,
               b0.out_lane_valid, b0.out_illegal);
    end
    total++;
    if (cnt0 !== 16'd0) begin
      bad++;
      $display("FAIL basic_cnt_before_pop got=%0d required=0", cnt0);
    end
    @(negedge clk);
    total++;
    if ({b0.out_valid, b0.out_op, cnt0} !== {1'b0, 8'h00, 16'd2}) begin
      bad++;
      $display("FAIL basic_after_pop got vld=%b op=%h cnt=%0d required vld=0 op=00 cnt=2",
               b0.out_valid, b0.out_op, cnt0);
    end
    b0.out_ready = 1'b0;
  endtask

  task automatic test_full();
    for (int k = 1; k <= 4; k++) begin
      b0.in_valid = 1'b1;
      b0.in_instr = {32'(k + 8) << 22, 32'(k) << 22};
      b0.in_lane_valid = 2'b11;
      @(negedge clk);
    end
    total++;
    if (b0.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_ready got=%b required=0", b0.in_ready);
    end
    b0.in_instr = {32'(13) << 22, 32'(5) << 22};
    @(negedge clk);
    b0.in_valid = 1'b0;
    total++;
    if ({b0.in_ready, b0.out_valid, b0.out_des} !== {1'b0, 1'b1, 8'h91}) begin
      bad++;
      $display("FAIL full_hold got rdy=%b vld=%b des=%h required rdy=0 vld=1 des=91",
               b0.in_ready, b0.out_valid, b0.out_des);
    end
    b0.out_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({b0.in_ready, b0.out_des} !== {1'b1, 8'hA2}) begin
      bad++;
      $display("FAIL full_first_pop got rdy=%b des=%h required rdy=1 des=a2",
               b0.in_ready, b0.out_des);
    end
    for (int k = 3; k <= 4; k++) begin
      @(negedge clk);
      total++;
      if ({b0.out_valid, b0.out_des[3:0]} !== {1'b1, 4'(k)}) begin
        bad++;
        $display("FAIL full_order got vld=%b des=%0d required vld=1 des=%0d",
                 b0.out_valid, b0.out_des[3:0], k);
      end
    end
    @(negedge clk);
    total++;
    if ({b0.out_valid, cnt0} !== {1'b0, 16'd10}) begin
      bad++;
      $display("FAIL full_drain got vld=%b cnt=%0d required vld=0 cnt=10",
               b0.out_valid, cnt0);
    end
    b0.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    b0.in_valid = 1'b1;
    b0.in_instr = {32'h0, 32'(1) << 22};
    b0.in_lane_valid = 2'b11;
    @(negedge clk);
    for (int j = 2; j <= 21; j++) begin
      total++;
      if ({b0.out_valid, b0.in_ready, b0.out_des[3:0]} !== {2'b11, 4'((j - 1) % 16)}) begin
        bad++;
        $display("FAIL stream_step%0d got vld=%b rdy=%b des=%0d required vld=1 rdy=1 des=%0d",
                 j, b0.out_valid, b0.in_ready, b0.out_des[3:0], (j - 1) % 16);
      end
      b0.in_instr = {32'h0, 32'(j % 16) << 22};
      b0.out_ready = 1'b1;
      @(negedge clk);
    end
    b0.in_valid = 1'b0;
    total++;
    if ({b0.out_valid, b0.out_des[3:0]} !== {1'b1, 4'd5}) begin
      bad++;
      $display("FAIL stream_last got vld=%b des=%0d required vld=1 des=5",
               b0.out_valid, b0.out_des[3:0]);
    end
    @(negedge clk);
    total++;
    if ({b0.out_valid, cnt0} !== {1'b0, 16'd52}) begin
      bad++;
      $display("FAIL stream_end got vld=%b cnt=%0d required vld=0 cnt=52",
               b0.out_valid, cnt0);
    end
    b0.out_ready = 1'b0;
  endtask

  task automatic test_strict();
    b0.in_valid = 1'b1;
    b1.in_valid = 1'b1;
    b0.in_instr = {32'h0, 32'hFC448000};
    b1.in_instr = {32'h0, 32'hFC448000};
    b0.in_lane_valid = 2'b01;
    b1.in_lane_valid = 2'b01;
    @(negedge clk);
    b0.in_valid = 1'b0;
    b1.in_valid = 1'b0;
    total++;
    if ({b1.out_valid, b1.out_op, b1.out_illegal, b1.out_lane_valid, b1.out_des,
         b1.out_s1, b1.out_s2, b1.out_imm}
        !== {1'b1, 8'h00, 2'b01, 2'b01, 8'h00, 8'h00, 8'h00, 10'h000}) begin
      bad++;
      $display("FAIL strict_illegal got vld=%b op=%h ill=%b lv=%b des=%h s1=%h s2=%h imm=%h required 1 00 01 01 00 00 00 000",
               b1.out_valid, b1.out_op, b1.out_illegal, b1.out_lane_valid, b1.out_des,
               b1.out_s1, b1.out_s2, b1.out_imm);
    end
    total++;
    if ({b0.out_op, b0.out_illegal, b0.out_s1, b0.out_s2, b0.out_des}
        !== {8'h01, 2'b00, 8'h01, 8'h02, 8'h00}) begin
      bad++;
      $display("FAIL lax_branch got op=%h ill=%b s1=%h s2=%h des=%h required 01 00 01 02 00",
               b0.out_op, b0.out_illegal, b0.out_s1, b0.out_s2, b0.out_des);
    end
    b0.out_ready = 1'b1;
    b1.out_ready = 1'b1;
    @(negedge clk);
    b0.out_ready = 1'b0;
    b1.out_ready = 1'b0;
    total++;
    if ({b1.out_valid, cnt1} !== {1'b0, 16'd1}) begin
      bad++;
      $display("FAIL strict_count got vld=%b cnt=%0d required vld=0 cnt=1",
               b1.out_valid, cnt1);
    end
  endtask

  task automatic test_trunc();
    b2.in_valid = 1'b1;
    b2.in_instr = {32'h8C440A00, 32'h00448000, 32'h10048A00, 32'h00448000};
    b2.in_lane_valid = 4'hF;
    @(negedge clk);
    b2.in_valid = 1'b0;
    total++;
    if ({b2.out_valid, b2.out_lane_valid, b2.out_op, b2.out_des, b2.out_s1, b2.out_s2, b2.out_imm}
        !== {1'b1, 4'b0011, 16'h0018, 16'h0001, 16'h0011, 16'h0022, 20'h000A0}) begin
      bad++;
      $display("FAIL trunc_bundle got vld=%b lv=%b op=%h des=%h s1=%h s2=%h imm=%h required 1 0011 0018 0001 0011 0022 000a0",
               b2.out_valid, b2.out_lane_valid, b2.out_op, b2.out_des, b2.out_s1,
               b2.out_s2, b2.out_imm);
    end
    b2.out_ready = 1'b1;
    @(negedge clk);
    b2.out_ready = 1'b0;
    total++;
    if (cnt2 !== 16'd2) begin
      bad++;
      $display("FAIL trunc_count got=%0d required=2", cnt2);
    end
  endtask

  task automatic test_saturate_and_reset();
    logic [2:0] exp_cnt [4];
    exp_cnt = '{3'd2, 3'd4, 3'd6, 3'd7};
    for (int k = 1; k <= 4; k++) begin
      b3.in_valid = 1'b1;
      b3.in_instr = {32'h0, 32'(k) << 22};
      b3.in_lane_valid = 2'b11;
      @(negedge clk);
    end
    b3.in_valid = 1'b0;
    b3.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (cnt3 !== exp_cnt[k]) begin
        bad++;
        $display("FAIL sat_pop%0d got=%0d required=%0d", k, cnt3, exp_cnt[k]);
      end
    end
    b3.out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      b3.in_valid = 1'b1;
      @(negedge clk);
    end
    b3.in_valid = 1'b0;
    total++;
    if (b3.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_valid got=%b required=1", b3.out_valid);
    end
    #1 reset = 1'b1;
    #1;
    total++;
    if ({b3.out_valid, cnt3, b3.in_ready, b3.out_des} !== {1'b0, 3'd0, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL async_reset got vld=%b cnt=%0d rdy=%b des=%h required vld=0 cnt=0 rdy=0 des=00",
               b3.out_valid, cnt3, b3.in_ready, b3.out_des);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    b0.in_valid = 1'b0; b0.in_instr = '0; b0.in_lane_valid = '0; b0.out_ready = 1'b0;
    b1.in_valid = 1'b0; b1.in_instr = '0; b1.in_lane_valid = '0; b1.out_ready = 1'b0;
    b2.in_valid = 1'b0; b2.in_instr = '0; b2.in_lane_valid = '0; b2.out_ready = 1'b0;
    b3.in_valid = 1'b0; b3.in_instr = '0; b3.in_lane_valid = '0; b3.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_full();
    test_back_to_back();
    test_strict();
    test_trunc();
    test_saturate_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
